writeback_unit: RTL and testbench

Final controller stage of the pipelined ARM32 core, directly downstream of the memory stage. It latches the instruction retired by the memory stage and drops it if its branch tag no longer matches the global branch reference. For loads (LDR) it waits on the data-memory read response, writes the returned word into register-file write port 2, and stalls the upstream pipeline while the response is outstanding. It also maintains a retired-instruction counter and a sticky load-timeout error flag.

---
 rtl/writeback_unit.sv | 130 +++++++++++++
 tb/tb_writeback_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | writeback_unit: retires memory-stage instructions, completes LDR writes |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module writeback_unit #(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        valid_in,
  input  logic        branch_in,
  input  logic        branch_ref,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [3:0]  w_addr2,
  output logic [31:0] w_data2,
  output logic        w_en2,
  output logic        stall_out,
  output logic [31:0] instr_output,
  output logic [31:0] retired_count,
  output logic        load_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] retired_count_q, retired_count_d;
  logic        load_err_q, load_err_d;
  logic        retire;
  logic        is_ldr;

  // opcode occupies [27:21]; opcode[6:3] maps to instr_q[27:24]
  assign is_ldr = valid_q && (instr_q[31:28] != 4'b1111) &&
                  ((instr_q[27:26] == 2'b11 && !instr_q[25]) ||
                   (instr_q[27:24] == 4'b1000));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_err_d = load_err_q;
    retire     = 1'b0;
    w_en2      = 1'b0;
    w_data2    = 32'd0;
    w_addr2    = instr_q[15:12];
    stall_out  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_ldr) begin
          if (mem_rvalid) begin
            w_en2   = 1'b1;
            w_data2 = mem_rdata;
            retire  = 1'b1;
          end else begin
            stall_out = 1'b1;
            state_d   = S_WAIT;
            cnt_d     = 8'd0;
          end
        end else if (valid_q) begin
          retire = 1'b1;
        end
      end
      S_WAIT: begin
        // a response arriving in the timeout cycle still completes the load
        if (mem_rvalid) begin
          w_en2   = 1'b1;
          w_data2 = mem_rdata;
          retire  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          load_err_d = 1'b1;
          retire     = 1'b1;
          state_d    = S_IDLE;
        end else begin
          stall_out = 1'b1;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    retired_count_d = retired_count_q + {31'd0, retire};

    instr_d = instr_q;
    valid_d = valid_q;
    if (!stall_out) begin
      if (branch_in == branch_ref) begin
        instr_d = instr_in;
        valid_d = valid_in;
      end else begin
        instr_d = 32'd0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      instr_q         <= 32'd0;
      valid_q         <= 1'b0;
      cnt_q           <= 8'd0;
      retired_count_q <= 32'd0;
      load_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      valid_q         <= valid_d;
      cnt_q           <= cnt_d;
      retired_count_q <= retired_count_d;
      load_err_q      <= load_err_d;
    end
  end

  assign instr_output  = instr_q;
  assign retired_count = retired_count_q;
  assign load_err      = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_writeback_unit: scoreboard bench for writeback_unit                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_writeback_unit;

  localparam int LT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        valid_in;
  logic        branch_in;
  logic        branch_ref;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [3:0]  w_addr2;
  logic [31:0] w_data2;
  logic        w_en2;
  logic        stall_out;
  logic [31:0] instr_output;
  logic [31:0] retired_count;
  logic        load_err;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_retired = 32'd0;
  logic        exp_err = 1'b0;

  writeback_unit #(.LOAD_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .valid_in(valid_in),
    .branch_in(branch_in), .branch_ref(branch_ref), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .w_addr2(w_addr2), .w_data2(w_data2), .w_en2(w_en2),
    .stall_out(stall_out), .instr_output(instr_output),
    .retired_count(retired_count), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] add_i(input logic [3:0] rd);
    return {16'hE080, rd, 12'h001};
  endfunction

  function automatic logic [31:0] ldr_i(input logic [3:0] rd);
    return {16'hEC10, rd, 12'h004};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_in = 32'hFFFF_FFFF; valid_in = 1'b1;
    branch_in = 1'b0; branch_ref = 1'b0; mem_rdata = 32'h1; mem_rvalid = 1'b1;
    step(); step();
    #1;
    n_checks++; if (w_en2 !== 1'b0) begin n_fail++; $display("FAIL reset_w_en2 got %b want 0", w_en2); end
    n_checks++; if (stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall_out); end
    n_checks++; if (instr_output !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr_output); end
    n_checks++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", retired_count); end
    n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", load_err); end
    n_checks++; if (w_data2 !== 32'd0 || w_addr2 !== 4'd0) begin n_fail++; $display("FAIL reset_wport got %h/%h want 0/0", w_addr2, w_data2); end
    instr_in = 32'd0; valid_in = 1'b0; mem_rvalid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // four ADDs then a cond=1111 no-op shaped like an LDR; stray mem_rvalid must be ignored
  task automatic test_nonload();
    logic [31:0] ins;
    for (int i = 0; i < 5; i++) begin
      ins = (i == 4) ? 32'hFC10_7000 : add_i(4'(i + 1));
      instr_in = ins; valid_in = 1'b1; branch_in = branch_ref;
      step();
      mem_rvalid = i[0]; mem_rdata = 32'hBAD0_0000 + i;
      #1;
      n_checks++; if (instr_output !== ins) begin n_fail++; $display("FAIL nl_instr[%0d] got %h want %h", i, instr_output, ins); end
      n_checks++; if (stall_out !== 1'b0 || w_en2 !== 1'b0) begin n_fail++; $display("FAIL nl_ctrl[%0d] got stall=%b wen=%b want 0/0", i, stall_out, w_en2); end
      n_checks++; if (w_data2 !== 32'd0 || w_addr2 !== ins[15:12]) begin n_fail++; $display("FAIL nl_wport[%0d] got %h/%h want %h/0", i, w_addr2, w_data2, ins[15:12]); end
      n_checks++; if (retired_count !== exp_retired) begin n_fail++; $display("FAIL nl_count[%0d] got %0d want %0d", i, retired_count, exp_retired); end
      exp_retired++;
    end
    instr_in = 32'd0; valid_in = 1'b0; mem_rvalid = 1'b0;
    step(); #1;
    n_checks++; if (retired_count !== exp_retired) begin n_fail++; $display("FAIL nl_final_count got %0d want %0d", retired_count, exp_retired); end
  endtask

  // LDR whose response arrives k cycles after it is first held
  task automatic test_load(input logic [3:0] rd, input logic [31:0] data, input int k);
    logic [31:0] li;
    logic [31:0] nxt;
    wr_t         e;
    li = ldr_i(rd); nxt = add_i(rd + 4'd1);
    instr_in = li; valid_in = 1'b1; branch_in = branch_ref; mem_rvalid = 1'b0;
    step();
    instr_in = nxt;
    for (int c = 0; c <= k; c++) begin
      mem_rvalid = (c == k);
      mem_rdata = (c == k) ? data : 32'hA5A5_A5A5;
      if (c == k) exp_q.push_back('{rd, data});
      #1;
      n_checks++; if (stall_out !== logic'(c < k)) begin n_fail++; $display("FAIL ld%0d_stall c%0d got %b want %b", rd, c, stall_out, c < k); end
      n_checks++; if (instr_output !== li) begin n_fail++; $display("FAIL ld%0d_hold c%0d got %h want %h", rd, c, instr_output, li); end
      if (w_en2 === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL ld%0d_extra_write c%0d got addr=%h data=%h want none", rd, c, w_addr2, w_data2);
        end else begin
          e = exp_q.pop_front();
          if (w_addr2 !== e.a || w_data2 !== e.d) begin n_fail++; $display("FAIL ld%0d_write got %h/%h want %h/%h", rd, w_addr2, w_data2, e.a, e.d); end
        end
      end else if (c == k) begin
        n_checks++; n_fail++; $display("FAIL ld%0d_missing_write got wen=%b want 1", rd, w_en2);
      end
      step();
    end
    mem_rvalid = 1'b0; exp_retired++;
    #1;
    n_checks++; if (instr_output !== nxt) begin n_fail++; $display("FAIL ld%0d_next_capture got %h want %h", rd, instr_output, nxt); end
    n_checks++; if (retired_count !== exp_retired) begin n_fail++; $display("FAIL ld%0d_count got %0d want %0d", rd, retired_count, exp_retired); end
    n_checks++; if (load_err !== exp_err) begin n_fail++; $display("FAIL ld%0d_err got %b want %b", rd, load_err, exp_err); end
    instr_in = 32'd0; valid_in = 1'b0;
    step(); exp_retired++;
  endtask

  task automatic test_squash();
    wr_t e;
    branch_ref = 1'b1; branch_in = 1'b0; instr_in = ldr_i(4'd2); valid_in = 1'b1;
    step();
    instr_in = 32'd0; valid_in = 1'b0; branch_in = 1'b1;
    #1;
    n_checks++; if (instr_output !== 32'd0 || stall_out !== 1'b0 || w_en2 !== 1'b0) begin n_fail++; $display("FAIL sq_bubble got %h/%b/%b want 0/0/0", instr_output, stall_out, w_en2); end
    step(); #1;
    n_checks++; if (retired_count !== exp_retired) begin n_fail++; $display("FAIL sq_count got %0d want %0d", retired_count, exp_retired); end
    // completing load while the incoming instruction is squashed
    instr_in = ldr_i(4'd4); valid_in = 1'b1; branch_in = 1'b1;
    step();
    instr_in = add_i(4'd9); branch_in = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    exp_q.push_back('{4'd4, 32'hCAFE_F00D});
    #1;
    n_checks++;
    if (w_en2 !== 1'b1 || exp_q.size() == 0) begin
      n_fail++; $display("FAIL sq_load_write got wen=%b want 1", w_en2);
    end else begin
      e = exp_q.pop_front();
      if (w_addr2 !== e.a || w_data2 !== e.d) begin n_fail++; $display("FAIL sq_load_data got %h/%h want %h/%h", w_addr2, w_data2, e.a, e.d); end
    end
    step();
    mem_rvalid = 1'b0; instr_in = 32'd0; valid_in = 1'b0; branch_in = 1'b1; exp_retired++;
    #1;
    n_checks++; if (instr_output !== 32'd0) begin n_fail++; $display("FAIL sq_next_squashed got %h want 0", instr_output); end
    step(); #1;
    n_checks++; if (retired_count !== exp_retired) begin n_fail++; $display("FAIL sq_final_count got %0d want %0d", retired_count, exp_retired); end
    branch_ref = 1'b0; branch_in = 1'b0;
  endtask

  task automatic test_timeout();
    instr_in = ldr_i(4'd6); valid_in = 1'b1; branch_in = branch_ref; mem_rvalid = 1'b0;
    step();
    instr_in = 32'd0; valid_in = 1'b0;
    for (int c = 0; c <= LT; c++) begin
      #1;
      n_checks++; if (stall_out !== logic'(c < LT)) begin n_fail++; $display("FAIL to_stall c%0d got %b want %b", c, stall_out, c < LT); end
      n_checks++; if (w_en2 !== 1'b0 || load_err !== 1'b0) begin n_fail++; $display("FAIL to_wen_err c%0d got %b/%b want 0/0", c, w_en2, load_err); end
      step();
    end
    exp_retired++; exp_err = 1'b1;
    #1;
    n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set got %b want 1", load_err); end
    n_checks++; if (stall_out !== 1'b0 || retired_count !== exp_retired) begin n_fail++; $display("FAIL to_idle got stall=%b count=%0d want 0/%0d", stall_out, retired_count, exp_retired); end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    step(); step(); #1;
    n_checks++; if (load_err !== 1'b1 || w_en2 !== 1'b0) begin n_fail++; $display("FAIL to_err_sticky got err=%b wen=%b want 1/0", load_err, w_en2); end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_reset_wait();
    force dut.retired_count_q = 32'hFFFF_FFF0;
    #1;
    release dut.retired_count_q;
    instr_in = ldr_i(4'd8); valid_in = 1'b1; branch_in = branch_ref; mem_rvalid = 1'b0;
    step();
    instr_in = add_i(4'd1);
    step(); step();
    #2;
    rst_n = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    n_checks++; if (w_en2 !== 1'b0 || stall_out !== 1'b0) begin n_fail++; $display("FAIL rw_ctrl got wen=%b stall=%b want 0/0", w_en2, stall_out); end
    n_checks++; if (instr_output !== 32'd0 || retired_count !== 32'd0 || load_err !== 1'b0) begin n_fail++; $display("FAIL rw_state got %h/%0d/%b want 0/0/0", instr_output, retired_count, load_err); end
    exp_retired = 32'd0; exp_err = 1'b0;
    step();
    mem_rvalid = 1'b0; instr_in = 32'd0; valid_in = 1'b0;
    rst_n = 1'b1;
    step(); #1;
    n_checks++; if (stall_out !== 1'b0 || w_en2 !== 1'b0 || retired_count !== 32'd0) begin n_fail++; $display("FAIL rw_after got stall=%b wen=%b count=%0d want 0/0/0", stall_out, w_en2, retired_count); end
  endtask

  task automatic test_wrap();
    instr_in = add_i(4'd2); valid_in = 1'b1; branch_in = branch_ref;
    step();
    instr_in = 32'd0; valid_in = 1'b0;
    force dut.retired_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count_q;
    step(); #1;
    n_checks++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL wrap_count got %h want 0", retired_count); end
  endtask

  initial begin
    test_reset();
    test_nonload();
    test_load(4'd3, 32'hDEAD_BEEF, 0);
    test_load(4'd5, 32'h1234_5678, 3);
    test_squash();
    test_load(4'd9, 32'h0BAD_F00D, LT);
    test_timeout();
    test_reset_wait();
    test_wrap();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
